// File: rtl/oh_clockmeasure.sv
// Measures the period and high time of a slow clock-like input against clk,
// reporting them in divider encoding with lock and timeout status.
module oh_clockmeasure #(
    parameter int CW    = 8,
    parameter int NLOCK = 8,
    parameter int SYNC  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          clkin,
    output logic          clkrise,
    output logic          clkfall,
    output logic          meas_valid,
    output logic [CW-1:0] div,
    output logic [CW-1:0] fall,
    output logic          locked,
    output logic          timeout
);

    localparam int MW = (NLOCK > 2) ? $clog2(NLOCK) : 1;
    localparam logic [MW-1:0] MMAX = MW'(NLOCK - 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t        state_q, state_d;
    logic          s;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] fcap_q, fcap_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] fall_q, fall_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          first_q, first_d;
    logic          meas_valid_q, meas_valid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;

    generate
        if (SYNC > 0) begin : g_sync
            logic [SYNC-1:0] sync_q, sync_d;
            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = clkin;
                for (int i = 1; i < SYNC; i++) sync_d[i] = sync_q[i-1];
            end
            always_ff @(posedge clk) begin
                if (reset) sync_q <= '0;
                else       sync_q <= sync_d;
            end
            assign s = sync_q[SYNC-1];
        end else begin : g_nosync
            assign s = clkin;
        end
    endgenerate

    assign clkrise = s & ~prev_q;
    assign clkfall = ~s & prev_q;

    always_comb begin
        state_d      = state_q;
        prev_d       = s;
        cnt_d        = clkrise ? '0 : ((cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1));
        fcap_d       = clkfall ? cnt_q + CW'(1) : fcap_q;
        div_d        = div_q;
        fall_d       = fall_q;
        mcnt_d       = mcnt_q;
        first_d      = first_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;

        if (clkrise) begin
            timeout_d = 1'b0;
            if (state_q == IDLE) begin
                // opening rise only marks the start of the first full period
                state_d = MEASURE;
                first_d = 1'b1;
            end else begin
                div_d        = cnt_q;
                fall_d       = fcap_q;
                meas_valid_d = 1'b1;
                first_d      = 1'b0;
                if (first_q || cnt_q != div_q || fcap_q != fall_q)
                    mcnt_d = '0;
                else if (mcnt_q != MMAX)
                    mcnt_d = mcnt_q + MW'(1);
                locked_d = (mcnt_d == MMAX);
            end
        end else if (cnt_q == CMAX) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            mcnt_d    = '0;
            state_d   = IDLE;
        end

        if (clear) begin
            state_d      = IDLE;
            cnt_d        = '0;
            mcnt_d       = '0;
            locked_d     = 1'b0;
            timeout_d    = 1'b0;
            meas_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            fcap_q       <= '0;
            div_q        <= '0;
            fall_q       <= '0;
            mcnt_q       <= '0;
            first_q      <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            fcap_q       <= fcap_d;
            div_q        <= div_d;
            fall_q       <= fall_d;
            mcnt_q       <= mcnt_d;
            first_q      <= first_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign div        = div_q;
    assign fall       = fall_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_oh_clockmeasure.sv
// Scoreboard bench for oh_clockmeasure: an edge-time model predicts each
// measurement when a rise is driven; a monitor checks every meas_valid pulse.
module tb_oh_clockmeasure;

    localparam int CW = 8;
    localparam int NL = 8;
    localparam int SY = 2;

    logic          clk = 1'b0;
    logic          reset, clear, clkin;
    logic          clkrise, clkfall, meas_valid, locked, timeout;
    logic [CW-1:0] div, fall;

    oh_clockmeasure #(.CW(CW), .NLOCK(NL), .SYNC(SY)) dut (
        .clk(clk), .reset(reset), .clear(clear), .clkin(clkin),
        .clkrise(clkrise), .clkfall(clkfall), .meas_valid(meas_valid),
        .div(div), .fall(fall), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int f;
        int lk;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle-time %0t)", nm, act, expv, $time);
        end
    endtask

    // Reference model in terms of driven edge times
    int cyc = 0;
    bit last_v = 0;
    int last_rise = 0, last_fall = 0;
    bit armed = 0, first = 0;
    int pdiv = 0, pfall = 0, streak = 0;
    bit watch_to = 0;

    task automatic drive(input bit v, input bit clr = 0, input bit rst = 0);
        int gap, d, f;
        @(negedge clk);
        cyc++;
        clkin = v;
        clear = clr;
        reset = rst;
        if (rst) begin
            armed = 0; last_v = 0; pdiv = 0; pfall = 0; streak = 0;
            return;
        end
        if (clr) armed = 0;
        if (v && !last_v) begin
            gap = cyc - last_rise;
            if (!armed) begin
                armed = 1; first = 1;
            end else if (gap > (1 << CW)) begin
                first = 1;
            end else begin
                d = gap - 1;
                f = last_fall - last_rise;
                if (first) streak = 0;
                else if (d == pdiv && f == pfall) streak = (streak < NL - 1) ? streak + 1 : streak;
                else streak = 0;
                first = 0; pdiv = d; pfall = f;
                exp_q.push_back('{d, f, (streak == NL - 1) ? 1 : 0});
            end
            last_rise = cyc;
        end
        if (!v && last_v) last_fall = cyc;
        last_v = v;
    endtask

    task automatic seg(input int p, input int h, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++) begin
                drive(i < h);
                if (watch_to) chk("timeout_long_period", int'(timeout), 0);
            end
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_meas_valid: got div=%0d fall=%0d expected no pulse", div, fall);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("div", int'(div), e.d);
                chk("fall", int'(fall), e.f);
                chk("locked", int'(locked), e.lk);
            end
        end
    end

    initial begin
        int r, c, lo;
        reset = 1; clear = 0; clkin = 0;
        repeat (3) drive(0, 0, 1);
        chk("rst_clkrise", int'(clkrise), 0);
        chk("rst_clkfall", int'(clkfall), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_div", int'(div), 0);
        chk("rst_fall", int'(fall), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_timeout", int'(timeout), 0);
        repeat (4) drive(0);

        seg(4, 2, 12);
        seg(5, 3, 12);

        // stuck low: timeout after the counter saturates
        r = last_rise;
        while (cyc < r + 300) begin
            drive(0);
            if (cyc - 1 == r + SY + 255) chk("timeout_early", int'(timeout), 0);
            if (cyc - 1 == r + SY + 256) begin
                chk("timeout_set", int'(timeout), 1);
                chk("timeout_unlock", int'(locked), 0);
            end
        end
        drive(1); r = cyc;
        drive(1); chk("timeout_hold", int'(timeout), 1);
        drive(1); chk("timeout_hold2", int'(timeout), 1);
        drive(0); chk("timeout_clr_on_rise", int'(timeout), 0);
        drive(0); drive(0);
        seg(6, 3, 10);

        // clear mid high phase while locked
        repeat (4) drive(1);
        drive(1, 1); c = cyc;
        drive(1);
        chk("clear_locked", int'(locked), 0);
        chk("clear_div", int'(div), pdiv);
        chk("clear_fall", int'(fall), pfall);
        chk("clear_meas_valid", int'(meas_valid), 0);
        repeat (4) drive(1);
        repeat (10) drive(0);
        seg(6, 3, 8);

        // two-stage sync latency
        repeat (10) drive(0);
        drive(1);
        drive(1); chk("sync_rise_edge_k", int'(clkrise), 0);
        drive(1); chk("sync_rise_edge_k1", int'(clkrise), 1);
        drive(1); chk("sync_rise_edge_k2", int'(clkrise), 0);
        drive(1);
        drive(1, 0, 1);
        drive(1);
        chk("mrst_clkrise", int'(clkrise), 0);
        chk("mrst_clkfall", int'(clkfall), 0);
        chk("mrst_meas_valid", int'(meas_valid), 0);
        chk("mrst_div", int'(div), 0);
        chk("mrst_fall", int'(fall), 0);
        chk("mrst_locked", int'(locked), 0);
        chk("mrst_timeout", int'(timeout), 0);
        repeat (3) drive(1);
        repeat (4) drive(0);
        seg(7, 2, 9);

        // longest measurable period
        watch_to = 1;
        seg(256, 1, 3);
        watch_to = 0;
        seg(3, 1, 10);

        // randomized segments, occasionally with long gaps near 2^CW
        for (int s = 0; s < 30; s++) begin
            int p, h, n;
            p = $urandom_range(2, 12);
            h = $urandom_range(1, p - 1);
            n = $urandom_range(1, 10);
            seg(p, h, n);
            if ($urandom_range(0, 7) == 0) begin
                lo = $urandom_range(245, 265);
                repeat (lo) drive(0);
            end
        end

        repeat (12) drive(0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
